// File: rtl/booth_r4_seq_multiplier_if.sv
// ----------------------------------------------------------------------------
// booth_r4_seq_multiplier_if
// Handshake and operand bundle for the sequential radix-4 Booth multiplier.
//
// Signals:
//   start        request to start a multiply (control unit -> multiplier)
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   multiplicand operand M, WIDTH bits
//   multiplier   operand Q, WIDTH bits
//   busy         operation in progress (multiplier -> control unit)
//   done         one-cycle pulse when the result becomes valid
//   product_lo   low half of the 2*WIDTH product
//   product_hi   high half of the 2*WIDTH product
//   overflow     product does not fit in WIDTH bits
//
// Modports:
//   master  control-unit side (drives operands and start)
//   slave   multiplier side (drives status and result)
// ----------------------------------------------------------------------------
interface booth_r4_seq_multiplier_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_lo;
    logic [WIDTH-1:0] product_hi;
    logic             overflow;

    modport master (
        output start,
        output signed_mode,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product_lo,
        input  product_hi,
        input  overflow
    );

    modport slave (
        input  start,
        input  signed_mode,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product_lo,
        output product_hi,
        output overflow
    );
endinterface

// File: rtl/booth_r4_seq_multiplier.sv
// ----------------------------------------------------------------------------
// booth_r4_seq_multiplier
// Sequential radix-4 Booth multiplier. Retires two multiplier bits per clock,
// supports signed and unsigned operands, and holds its registered result
// (with an overflow flag) until the next accepted start.
//
// Ports:
//   i_clk   clock, all state changes on the rising edge
//   i_clr   synchronous active-low reset
//   io_bus  slave side of booth_r4_seq_multiplier_if
//           (start/signed_mode/multiplicand/multiplier in,
//            busy/done/product_lo/product_hi/overflow out)
//
// Timing: start sampled at edge t -> busy in cycles t+1..t+ITER,
//         done pulse with valid result in cycle t+ITER+1.
// ----------------------------------------------------------------------------
module booth_r4_seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input logic                            i_clk,
    input logic                            i_clr,
    booth_r4_seq_multiplier_if.slave       io_bus
);
    localparam int unsigned ITER = WIDTH / 2 + 1;
    localparam int unsigned EXTW = WIDTH + 2;     // extended operand width
    localparam int unsigned ACCW = WIDTH + 4;     // accumulator width, holds +/-2M
    localparam int unsigned CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [EXTW-1:0]  r_m;
    logic [EXTW-1:0]  r_q;
    logic             r_qprev;
    logic [ACCW-1:0]  r_acc;
    logic             r_signed;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_ovf;

    logic [2:0]         w_triple;
    logic [ACCW-1:0]    w_m_ext;
    logic [ACCW-1:0]    w_addend;
    logic [ACCW-1:0]    w_sum;
    logic [ACCW-1:0]    w_acc_next;
    logic [EXTW-1:0]    w_q_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_prod_hi;
    logic [WIDTH-1:0]   w_prod_lo;
    logic               w_ovf;
    logic [EXTW-1:0]    w_m_load;
    logic [EXTW-1:0]    w_q_load;

    // Operand extension applied at capture time.
    assign w_m_load = io_bus.signed_mode
                    ? {{2{io_bus.multiplicand[WIDTH-1]}}, io_bus.multiplicand}
                    : {2'b00, io_bus.multiplicand};
    assign w_q_load = io_bus.signed_mode
                    ? {{2{io_bus.multiplier[WIDTH-1]}}, io_bus.multiplier}
                    : {2'b00, io_bus.multiplier};

    // Booth recoding of {Q[1], Q[0], q_prev}.
    assign w_triple = {r_q[1:0], r_qprev};
    assign w_m_ext  = {{2{r_m[EXTW-1]}}, r_m};

    always_comb begin
        w_addend = '0;
        case (w_triple)
            3'b001, 3'b010: w_addend = w_m_ext;
            3'b011:         w_addend = w_m_ext << 1;
            3'b100:         w_addend = -(w_m_ext << 1);
            3'b101, 3'b110: w_addend = -w_m_ext;
            default:        w_addend = '0;
        endcase
    end

    assign w_sum = r_acc + w_addend;

    // Arithmetic shift right by 2 of {acc, Q, q_prev}; q_prev becomes old Q[1].
    assign w_acc_next = {{2{w_sum[ACCW-1]}}, w_sum[ACCW-1:2]};
    assign w_q_next   = {w_sum[1:0], r_q[EXTW-1:2]};

    // After the last step Q holds the low WIDTH+2 product bits and the
    // accumulator the rest, sign-extended; keep the low 2*WIDTH bits.
    assign w_prod    = {w_acc_next[WIDTH-3:0], w_q_next};
    assign w_prod_hi = w_prod[2*WIDTH-1:WIDTH];
    assign w_prod_lo = w_prod[WIDTH-1:0];
    assign w_ovf     = r_signed ? (w_prod_hi != {WIDTH{w_prod_lo[WIDTH-1]}})
                                : (w_prod_hi != '0);

    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_qprev  <= 1'b0;
            r_acc    <= '0;
            r_signed <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    r_done <= 1'b0;
                    if (io_bus.start) begin
                        r_m      <= w_m_load;
                        r_q      <= w_q_load;
                        r_qprev  <= 1'b0;
                        r_acc    <= '0;
                        r_signed <= io_bus.signed_mode;
                        r_cnt    <= CW'(ITER);
                        r_busy   <= 1'b1;
                        r_state  <= StRun;
                    end else begin
                        r_state  <= StIdle;
                    end
                end
                StRun: begin
                    r_acc   <= w_acc_next;
                    r_q     <= w_q_next;
                    r_qprev <= r_q[1];
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_hi    <= w_prod_hi;
                        r_lo    <= w_prod_lo;
                        r_ovf   <= w_ovf;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.busy       = r_busy;
    assign io_bus.done       = r_done;
    assign io_bus.product_lo = r_lo;
    assign io_bus.product_hi = r_hi;
    assign io_bus.overflow   = r_ovf;

endmodule
